// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

  localparam int ILEN = 32;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [XLEN_DEFAULT-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [ILEN-1:0]         instr;
  } fetch_entry_t;

  // Enough bits to hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Show-ahead FIFO of fetched instructions; flush empties it in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  parameter int  CW      = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  entry_t        push_data_i,
  input  logic          pop_i,
  output entry_t        head_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] count_q;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= ptr_inc(wr_q);
      if (pop_i)  rd_q <= ptr_inc(rd_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests IMEM words, queues them for decode.
// Optional macro FETCH_MISALIGN_TRAP_EN traps misaligned redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int              QUEUE_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misaligned,
  output logic [XLEN-1:0] fetch_bad_pc
`endif
);

  localparam int CW = count_width(QUEUE_DEPTH);
  localparam int RW = CW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            inflight_q;
  logic            req_epoch_q;
  logic            epoch_q;

  logic [CW-1:0]   count;
  logic [RW-1:0]   reserved;
  logic            deq;
  logic            req;
  logic            enq;
  logic            halt;
  logic [XLEN-1:0] target;
  entry_t          push_entry;
  entry_t          head;

  // Decode handshake: a transfer happens on a posedge where instr_valid and
  // instr_ready are both high; the head stays put until transferred, flushed or reset.
  assign deq = instr_valid & instr_ready;

  // Every inflight request already owns a queue slot, so the queue cannot overflow.
  assign reserved = {1'b0, count} + RW'(inflight_q) - RW'(deq);
  assign req      = reset_n & ~redirect_valid & ~halt & (reserved < RW'(QUEUE_DEPTH));
  assign target   = redirect_pc & ~XLEN'(3);

  // Late responses from a squashed epoch never reach the queue.
  assign enq        = inflight_q & ~redirect_valid & (req_epoch_q == epoch_q);
  assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_VECTOR;
      req_pc_q    <= '0;
      inflight_q  <= 1'b0;
      req_epoch_q <= 1'b0;
      epoch_q     <= 1'b0;
    end else begin
      inflight_q <= req;
      if (req) begin
        req_pc_q    <= pc_q;
        req_epoch_q <= epoch_q;
        pc_q        <= pc_q + XLEN'(INSTR_BYTES);
      end
      if (redirect_valid) begin
        pc_q    <= target;
        epoch_q <= ~epoch_q;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misaligned_q;
  logic [XLEN-1:0] bad_pc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misaligned_q <= 1'b0;
      bad_pc_q     <= '0;
    end else if (redirect_valid) begin
      misaligned_q <= |redirect_pc[1:0];
      if (|redirect_pc[1:0]) bad_pc_q <= redirect_pc;
    end
  end

  assign halt             = misaligned_q;
  assign fetch_misaligned = misaligned_q;
  assign fetch_bad_pc     = bad_pc_q;
`else
  assign halt = 1'b0;
`endif

  fetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (entry_t),
    .CW      (CW)
  ) u_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (redirect_valid),
    .push_i      (enq),
    .push_data_i (push_entry),
    .pop_i       (deq & ~redirect_valid),
    .head_o      (head),
    .count_o     (count)
  );

  assign imem_req_valid = req;
  assign imem_addr      = pc_q;
  assign instr_valid    = (count != '0);
  assign instr          = instr_valid ? head.instr : '0;
  assign instr_pc       = instr_valid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: IMEM model, dequeue scoreboard, step-by-step checks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
  logic [31:0] fetch_bad_pc;
`endif

  int          n_assert = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic        hold_prev = 1'b0;
  logic [63:0] head_prev = '0;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .QUEUE_DEPTH  (4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .imem_req_valid   (imem_req_valid),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr            (instr),
    .instr_pc         (instr_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned),
    .fetch_bad_pc     (fetch_bad_pc)
`endif
  );

  // IMEM: word k holds 0x1000_0000 + k, one cycle after the request; junk otherwise.
  always @(posedge clk) begin
    if (imem_req_valid) imem_rdata <= 32'h1000_0000 + (imem_addr >> 2);
    else                imem_rdata <= 32'($urandom_range(32'h7FFF_FFFF, 0));
  end

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, 32'h1000_0000 + (pc >> 2)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: every accepted instruction is popped and compared; stalled heads must hold.
  always @(negedge clk) begin
    if (hold_prev && reset_n) begin
      check("head_hold_valid", 64'(instr_valid), 64'd1);
      check("head_hold_data", {instr_pc, instr}, head_prev);
    end
    if (reset_n && instr_valid && instr_ready && !redirect_valid) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed pc=%h instr=%h expected no instruction", instr_pc, instr);
      end
      if (exp_q.size() != 0) check("sb_instr", {instr_pc, instr}, exp_q.pop_front());
    end
    hold_prev = reset_n && instr_valid && !instr_ready && !redirect_valid;
    head_prev = {instr_pc, instr};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) tick();
    at_neg();
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_misaligned", 64'(fetch_misaligned), 64'd0);
    check("rst_bad_pc", 64'(fetch_bad_pc), 64'd0);
`endif

    // Reset release with decode always ready: latency 2, then one per cycle.
    tick();
    reset_n     = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(32'(i * 4)));
    at_neg();
    check("first_req_valid", 64'(imem_req_valid), 64'd1);
    check("first_req_addr", 64'(imem_addr), 64'h0);
    tick(); at_neg();
    check("lat_r1_valid", 64'(instr_valid), 64'd0);
    tick(); at_neg();
    check("lat_r2_valid", 64'(instr_valid), 64'd1);
    check("lat_r2_pc", 64'(instr_pc), 64'h0);
    for (int i = 0; i < 7; i++) begin
      tick(); at_neg();
      check("stream_valid", 64'(instr_valid), 64'd1);
    end
    tick();
    instr_ready = 1'b0;

    // Backpressure from a fresh start at 0x0: queue fills to 4, pc parks at 0x10.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    exp_q.delete();
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    at_neg();
    check("full_valid", 64'(instr_valid), 64'd1);
    check("full_head_pc", 64'(instr_pc), 64'h0);
    check("full_no_req", 64'(imem_req_valid), 64'd0);
    check("full_pc", 64'(imem_addr), 64'h10);
    for (int i = 0; i < 6; i++) exp_q.push_back(ent(32'(i * 4)));
    tick();
    instr_ready = 1'b1;
    at_neg();
    check("drain_valid", 64'(instr_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick(); at_neg();
      check("drain_valid", 64'(instr_valid), 64'd1);
    end
    tick();
    instr_ready = 1'b0;

    // Redirect to 0x200 with 3 entries queued, decode ready in the same cycle.
    repeat (8) tick();
    exp_q.push_back(ent(32'h18));
    instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(ent(32'h200 + 32'(i * 4)));
    at_neg();
    check("redir_n_no_req", 64'(imem_req_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    at_neg();
    check("redir_n1_valid", 64'(instr_valid), 64'd0);
    check("redir_n1_req", 64'(imem_req_valid), 64'd1);
    check("redir_n1_addr", 64'(imem_addr), 64'h200);
    tick(); at_neg();
    check("redir_n2_valid", 64'(instr_valid), 64'd0);
    tick(); at_neg();
    check("redir_n3_valid", 64'(instr_valid), 64'd1);
    check("redir_n3_pc", 64'(instr_pc), 64'h200);
    for (int i = 0; i < 5; i++) begin
      tick(); at_neg();
      check("redir_stream_valid", 64'(instr_valid), 64'd1);
    end
    tick();
    instr_ready = 1'b0;

    // Back-to-back redirects: only the 0x400 stream may ever be accepted.
    repeat (3) tick();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    exp_q.delete();
    tick();
    redirect_pc = 32'h400;
    for (int i = 0; i < 6; i++) exp_q.push_back(ent(32'h400 + 32'(i * 4)));
    tick();
    redirect_valid = 1'b0;
    at_neg();
    check("b2b_addr", 64'(imem_addr), 64'h400);
    wait_drain("b2b_drain", 30);
    instr_ready = 1'b0;

    // PC wraps from 0xFFFF_FFFC to 0x0.
    tick();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    exp_q.delete();
    exp_q.push_back(ent(32'hFFFF_FFF8));
    exp_q.push_back(ent(32'hFFFF_FFFC));
    for (int i = 0; i < 3; i++) exp_q.push_back(ent(32'(i * 4)));
    tick();
    redirect_valid = 1'b0;
    at_neg();
    check("wrap_addr0", 64'(imem_addr), 64'hFFFF_FFF8);
    tick(); at_neg();
    check("wrap_addr1", 64'(imem_addr), 64'hFFFF_FFFC);
    tick(); at_neg();
    check("wrap_addr2", 64'(imem_addr), 64'h0);
    check("wrap_req2", 64'(imem_req_valid), 64'd1);
    wait_drain("wrap_drain", 30);
    instr_ready = 1'b0;

    // Misaligned redirect target 0x206.
    tick();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h206;
    exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
    tick();
    redirect_valid = 1'b0;
    at_neg();
    check("mis_flag", 64'(fetch_misaligned), 64'd1);
    check("mis_bad_pc", 64'(fetch_bad_pc), 64'h206);
    check("mis_no_req", 64'(imem_req_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); at_neg();
      check("mis_halt_req", 64'(imem_req_valid), 64'd0);
      check("mis_halt_valid", 64'(instr_valid), 64'd0);
    end
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(32'h100 + 32'(i * 4)));
    tick();
    redirect_valid = 1'b0;
    at_neg();
    check("mis_clear_flag", 64'(fetch_misaligned), 64'd0);
    check("mis_clear_req", 64'(imem_req_valid), 64'd1);
    check("mis_clear_addr", 64'(imem_addr), 64'h100);
    wait_drain("mis_clear_drain", 30);
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(32'h204 + 32'(i * 4)));
    tick();
    redirect_valid = 1'b0;
    at_neg();
    check("align_req", 64'(imem_req_valid), 64'd1);
    check("align_addr", 64'(imem_addr), 64'h204);
    wait_drain("align_drain", 30);
`endif
    instr_ready = 1'b0;

    // Reset mid-stream with a request outstanding: the old response must vanish.
    tick();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    exp_q.delete();
    exp_q.push_back(ent(32'h500));
    exp_q.push_back(ent(32'h504));
    tick();
    redirect_valid = 1'b0;
    wait_drain("pre_reset_drain", 20);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid", 64'(instr_valid), 64'd0);
    check("midrst_req", 64'(imem_req_valid), 64'd0);
    check("midrst_instr_pc", 64'(instr_pc), 64'h0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(32'(i * 4)));
    at_neg();
    check("postrst_req", 64'(imem_req_valid), 64'd1);
    check("postrst_addr", 64'(imem_addr), 64'h0);
    wait_drain("postrst_drain", 20);
    instr_ready = 1'b0;

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
